// File: rtl/counter_modn_updown.sv
// Modulo-MODULUS up/down counter with enable, parallel load, terminal count and wrap/ld_err pulses.
// Define COUNTER_SATURATE_EN to hold at the count limit instead of wrapping.
module counter_modn_updown #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MODULUS   = 10,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             ld_err
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic             r_ld_err;

   logic [WIDTH-1:0] w_q_nxt;
   logic             w_wrap_nxt;
   logic             w_ld_err_nxt;
   logic             w_at_lim;

   assign w_at_lim = up ? (r_q == MaxVal) : (r_q == '0);

   always_comb begin
      w_q_nxt      = r_q;
      w_wrap_nxt   = 1'b0;
      w_ld_err_nxt = 1'b0;
      if (load) begin
         // d > MaxVal is d >= MODULUS without widening d past WIDTH bits
         if (d > MaxVal) begin
            w_q_nxt      = MaxVal;
            w_ld_err_nxt = 1'b1;
         end else begin
            w_q_nxt = d;
         end
      end else if (en) begin
         if (w_at_lim) begin
            w_wrap_nxt = 1'b1;
`ifdef COUNTER_SATURATE_EN
            w_q_nxt    = r_q;
`else
            w_q_nxt    = up ? '0 : MaxVal;
`endif
         end else begin
            w_q_nxt = up ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_q      <= RstVal;
         r_wrap   <= 1'b0;
         r_ld_err <= 1'b0;
      end else begin
         r_q      <= w_q_nxt;
         r_wrap   <= w_wrap_nxt;
         r_ld_err <= w_ld_err_nxt;
      end
   end

   assign q      = r_q;
   assign tc     = en & ~load & w_at_lim;
   assign wrap   = r_wrap;
   assign ld_err = r_ld_err;

endmodule

// File: tb/tb_counter_modn_updown.sv
// Scoreboard bench for counter_modn_updown (WIDTH=4, MODULUS=10, RESET_VAL=0) plus a two-stage
// cascade; honours COUNTER_SATURATE_EN in its reference model.
module tb_counter_modn_updown;

   localparam int unsigned W = 4;
   localparam int unsigned M = 10;

   typedef struct {
      logic [W-1:0] q;
      logic         wrap;
      logic         ld_err;
   } exp_t;

   logic         clk = 1'b0;
   logic         clear = 1'b0;
   logic         en = 1'b0;
   logic         up = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] d = '0;
   logic [W-1:0] q;
   logic         tc;
   logic         wrap;
   logic         ld_err;

   logic         c_en = 1'b0;
   logic [W-1:0] lo_q, hi_q;
   logic         lo_tc, hi_tc, lo_wrap, hi_wrap, lo_ld_err, hi_ld_err;

   int   n_tests = 0;
   int   n_fail = 0;
   int   m_q = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   counter_modn_updown #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) u_dut (
      .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .d(d),
      .q(q), .tc(tc), .wrap(wrap), .ld_err(ld_err)
   );

   counter_modn_updown #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) u_lo (
      .clk(clk), .clear(clear), .en(c_en), .up(1'b1), .load(1'b0), .d('0),
      .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .ld_err(lo_ld_err)
   );

   counter_modn_updown #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) u_hi (
      .clk(clk), .clear(clear), .en(lo_tc), .up(1'b1), .load(1'b0), .d('0),
      .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .ld_err(hi_ld_err)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, check tc, push the model result, compare after the edge.
   task automatic step(input logic i_en, input logic i_up, input logic i_load,
                       input logic [W-1:0] i_d);
      exp_t e;
      logic exp_tc;
      en = i_en; up = i_up; load = i_load; d = i_d;
      #1;
      exp_tc = i_en & ~i_load & (i_up ? (m_q == M - 1) : (m_q == 0));
      check_val("tc", tc, exp_tc);
      e.q = W'(m_q); e.wrap = 1'b0; e.ld_err = 1'b0;
      if (i_load) begin
         if (int'(i_d) >= M) begin
            e.q = W'(M - 1); e.ld_err = 1'b1;
         end else begin
            e.q = i_d;
         end
      end else if (i_en) begin
         if (i_up ? (m_q == M - 1) : (m_q == 0)) begin
            e.wrap = 1'b1;
`ifndef COUNTER_SATURATE_EN
            e.q = i_up ? W'(0) : W'(M - 1);
`endif
         end else begin
            e.q = i_up ? W'(m_q + 1) : W'(m_q - 1);
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check_val("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check_val("q", q, e.q);
         check_val("wrap", wrap, e.wrap);
         check_val("ld_err", ld_err, e.ld_err);
         m_q = int'(e.q);
      end
      en = 1'b0; load = 1'b0;
   endtask

   // Assert clear between edges and confirm the outputs drop without a clock.
   task automatic do_clear();
      #2 clear = 1'b0;
      #1;
      check_val("clr_q", q, 0);
      check_val("clr_wrap", wrap, 0);
      check_val("clr_ld_err", ld_err, 0);
      #1 clear = 1'b1;
      m_q = 0;
   endtask

   initial begin
      int n_hi_wrap;
      #2;
      check_val("rst_q", q, 0);
      check_val("rst_wrap", wrap, 0);
      check_val("rst_ld_err", ld_err, 0);
      #10 clear = 1'b1;
      @(posedge clk);
      #1;

      // Count up 12 edges through the wrap.
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);

      // Down from 2 through zero.
      step(1'b0, 1'b1, 1'b1, 4'd2);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);

      // Loads: in range, out of range, pulse drop, load beats enable.
      step(1'b1, 1'b0, 1'b1, 4'd7);
      step(1'b0, 1'b1, 1'b1, 4'd12);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 1'b1, 4'd3);
      step(1'b1, 1'b1, 1'b1, 4'd15);

      // Clear while ld_err is high, then while wrap is high, then mid-count at 6.
      do_clear();
      step(1'b0, 1'b1, 1'b1, 4'd9);
      step(1'b1, 1'b1, 1'b0, '0);
      do_clear();
      step(1'b0, 1'b1, 1'b1, 4'd5);
      step(1'b1, 1'b1, 1'b0, '0);
      do_clear();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

      // Limit behaviour (wrap or saturate depending on build), and hold.
      step(1'b0, 1'b1, 1'b1, 4'd8);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, 4'd1);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, '0);

`ifndef COUNTER_SATURATE_EN
      // Two-stage decade cascade.
      do_clear();
      n_hi_wrap = 0;
      c_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (hi_wrap) n_hi_wrap++;
         if (i == 9) begin
            check_val("casc10_lo", lo_q, 0);
            check_val("casc10_hi", hi_q, 1);
         end
      end
      c_en = 1'b0;
      check_val("casc100_lo", lo_q, 0);
      check_val("casc100_hi", hi_q, 0);
      check_val("casc_hi_wraps", n_hi_wrap, 1);
`endif

      check_val("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
